// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: hands one single-port SRAM to either the host or the
// corelet. Ownership follows host_sel and is switched through a DRAIN state
// that waits for in-flight reads to complete. Read-valid is routed back only
// to the side that issued the read.
//
// Optional build macro: ARB_STATS_EN enables the saturating deny_cnt
// statistics counter. When it is undefined, deny_cnt is tied to zero.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   host_sel            requested owner (1 = host, 0 = core)
//   owner, owner_vld    registered current owner and owner-valid
//   host_*/core_*       req/we/addr/wdata in; gnt (comb), rvalid (reg) out
//   rdata               SRAM Q pass-through
//   sram_cen/wen/a/d    SRAM drive (active-low CEN/WEN), sram_q read data
//   deny_cnt            denied-request cycle counter
module sram_access_arbiter #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 7,
  parameter int unsigned RD_LAT = 1   // legal range 1..4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_sel,
  output logic          owner,
  output logic          owner_vld,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] rdata,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  input  logic [DW-1:0] sram_q,
  output logic [15:0]   deny_cnt
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OWN_CORE = 2'd1,
    OWN_HOST = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Read tracking split per side: each bit is {valid & tag} for that side.
  logic [RD_LAT-1:0] host_pipe;
  logic [RD_LAT-1:0] core_pipe;
  logic              pipe_empty;
  logic              acc_we;
  logic              rd_issue;

  assign pipe_empty = ~|(host_pipe | core_pipe);

  // Grants: only the current owner, and only while host_sel still agrees.
  assign host_gnt = host_req & (state == OWN_HOST) &  host_sel;
  assign core_gnt = core_req & (state == OWN_CORE) & ~host_sel;

  assign acc_we   = host_gnt ? host_we : core_we;
  assign rd_issue = (host_gnt | core_gnt) & ~acc_we;

  // SRAM drive from the granted side, quiet levels otherwise.
  always_comb begin
    sram_cen = 1'b1;
    sram_wen = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    if (host_gnt) begin
      sram_cen = 1'b0;
      sram_wen = ~host_we;
      sram_a   = host_addr;
      sram_d   = host_wdata;
    end else if (core_gnt) begin
      sram_cen = 1'b0;
      sram_wen = ~core_we;
      sram_a   = core_addr;
      sram_d   = core_wdata;
    end
  end

  assign rdata = sram_q;

  // Next-state: ownership follows host_sel; DRAIN waits for an empty pipeline.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     state_nxt = host_sel ? OWN_HOST : OWN_CORE;
      OWN_CORE: if (host_sel)  state_nxt = DRAIN;
      OWN_HOST: if (!host_sel) state_nxt = DRAIN;
      DRAIN:    if (pipe_empty) state_nxt = host_sel ? OWN_HOST : OWN_CORE;
      default:  state_nxt = IDLE;
    endcase
  end

  // State and registered ownership outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      owner_vld <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= (state_nxt == OWN_HOST);
      owner_vld <= (state_nxt == OWN_HOST) || (state_nxt == OWN_CORE);
    end
  end

  // Read pipeline: the last stage is the per-side rvalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_pipe <= '0;
      core_pipe <= '0;
    end else begin
      host_pipe[0] <= rd_issue &  host_gnt;
      core_pipe[0] <= rd_issue & ~host_gnt;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        host_pipe[i] <= host_pipe[i-1];
        core_pipe[i] <= core_pipe[i-1];
      end
    end
  end

  assign host_rvalid = host_pipe[RD_LAT-1];
  assign core_rvalid = core_pipe[RD_LAT-1];

`ifdef ARB_STATS_EN
  // Saturating count of cycles with at least one ungranted request.
  logic             deny;
  logic [CNT_W-1:0] deny_q;

  assign deny = (host_req & ~host_gnt) | (core_req & ~core_gnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deny_q <= '0;
    end else if (deny && (deny_q != {CNT_W{1'b1}})) begin
      deny_q <= deny_q + CNT_W'(1);
    end
  end

  assign deny_cnt = deny_q;
`else
  assign deny_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter with an SRAM model and a read
// scoreboard checked by an independent rvalid monitor.
module tb_sram_access_arbiter;

  localparam int unsigned DW     = 32;
  localparam int unsigned AW     = 7;
  localparam int unsigned RD_LAT = 3;
`ifdef ARB_STATS_EN
  localparam int EXP_DENY = 10;
`else
  localparam int EXP_DENY = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          host_sel;
  logic          owner, owner_vld;
  logic          host_req, host_we, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          core_req, core_we, core_gnt, core_rvalid;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [DW-1:0] rdata;
  logic          sram_cen, sram_wen;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;
  logic [15:0]   deny_cnt;

  always #5 clk = ~clk;

  sram_access_arbiter #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .host_sel(host_sel),
    .owner(owner), .owner_vld(owner_vld),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .rdata(rdata), .sram_cen(sram_cen), .sram_wen(sram_wen),
    .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q), .deny_cnt(deny_cnt)
  );

  // SRAM model: unwritten words read as 32'hA5A5_0000 + address.
  logic                mdl_init_n;
  logic [DW-1:0]       mem [0:(1<<AW)-1];
  logic [(1<<AW)-1:0]  wr_done;
  logic [DW-1:0]       qpipe [RD_LAT];

  always @(posedge clk) begin
    if (!mdl_init_n) wr_done <= '0;
    else if (!sram_cen && !sram_wen) begin
      mem[sram_a]     <= sram_d;
      wr_done[sram_a] <= 1'b1;
    end
    if (!sram_cen && sram_wen)
      qpipe[0] <= wr_done[sram_a] ? mem[sram_a] : (32'hA5A5_0000 + DW'(sram_a));
    else
      qpipe[0] <= '0;
    for (int i = 1; i < int'(RD_LAT); i++) qpipe[i] <= qpipe[i-1];
  end
  assign sram_q = qpipe[RD_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          side;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   host_pulses = 0;
  int   core_pulses = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_rd(input logic side, input logic [DW-1:0] d);
    sb.push_back('{side, d, cyc + int'(RD_LAT)});
  endtask

  // Monitor: every rvalid pops one expected read and checks side, data, cycle.
  always @(negedge clk) begin
    exp_t e;
    if (host_rvalid) host_pulses++;
    if (core_rvalid) core_pulses++;
    if (host_rvalid || core_rvalid) begin
      chk("rvalid_exclusive", 64'(host_rvalid & core_rvalid), 64'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_unexpected: host_rvalid %0b core_rvalid %0b with no read outstanding (cycle %0d)",
                 host_rvalid, core_rvalid, cyc);
      end else begin
        e = sb.pop_front();
        chk("rvalid_side", 64'(host_rvalid), 64'(e.side));
        chk("rdata", 64'(rdata), 64'(e.data));
        chk("rvalid_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic wait_owner(input logic want, output int at);
    at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (owner_vld && (owner == want)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL owner_wait: owner %0b not valid within 20 cycles", want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int at, c_start, h0, c0, hg, cg;
    reset = 1'b0; mdl_init_n = 1'b0; host_sel = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_owner_vld", 64'(owner_vld), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_cen", 64'(sram_cen), 64'd1);
    chk("rst_wen", 64'(sram_wen), 64'd1);
    chk("rst_deny", 64'(deny_cnt), 64'd0);

    // Reset release with a held core read of address 5.
    @(negedge clk);
    mdl_init_n = 1'b1; reset = 1'b1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 7'h05;
    #1;
    chk("idle_core_gnt", 64'(core_gnt), 64'd0);
    chk("idle_owner_vld", 64'(owner_vld), 64'd0);
    @(negedge clk); #1;
    chk("s1_core_gnt", 64'(core_gnt), 64'd1);
    chk("s1_cen", 64'(sram_cen), 64'd0);
    chk("s1_wen", 64'(sram_wen), 64'd1);
    chk("s1_addr", 64'(sram_a), 64'h5);
    chk("s1_owner", 64'({owner_vld, owner}), 64'b10);
    expect_rd(1'b0, 32'hA5A5_0005);
    @(negedge clk);
    core_req = 1'b0;
    host_sel = 1'b1;

    // Host write then back-to-back reads.
    wait_owner(1'b1, at);
    host_req = 1'b1; host_we = 1'b1; host_addr = 7'h03; host_wdata = 32'hDEADBEEF;
    #1;
    chk("s2_wr_gnt", 64'(host_gnt), 64'd1);
    chk("s2_wr_wen", 64'(sram_wen), 64'd0);
    chk("s2_wr_addr", 64'(sram_a), 64'h3);
    chk("s2_wr_data", 64'(sram_d), 64'hDEADBEEF);
    @(negedge clk);
    host_we = 1'b0;
    #1;
    chk("s2_rd_gnt", 64'(host_gnt), 64'd1);
    chk("s2_rd_wen", 64'(sram_wen), 64'd1);
    expect_rd(1'b1, 32'hDEADBEEF);
    @(negedge clk);
    host_addr = 7'h05;
    #1;
    chk("s2_rd2_gnt", 64'(host_gnt), 64'd1);
    expect_rd(1'b1, 32'hA5A5_0005);
    @(negedge clk);
    host_req = 1'b0; host_sel = 1'b0;
    #1;
    chk("s2_quiet_cen", 64'(sram_cen), 64'd1);
    chk("s2_quiet_addr", 64'(sram_a), 64'h0);

    // Ownership switch to host with two core reads in flight.
    wait_owner(1'b0, at);
    h0 = host_pulses; c0 = core_pulses;
    core_req = 1'b1; core_we = 1'b0; core_addr = 7'h01;
    #1;
    chk("s3_rd1_gnt", 64'(core_gnt), 64'd1);
    expect_rd(1'b0, 32'hA5A5_0001);
    @(negedge clk);
    core_addr = 7'h02;
    #1;
    chk("s3_rd2_gnt", 64'(core_gnt), 64'd1);
    expect_rd(1'b0, 32'hA5A5_0002);
    @(negedge clk);
    core_addr = 7'h04; host_sel = 1'b1;
    #1;
    chk("s3_rd3_gnt", 64'(core_gnt), 64'd0);
    c_start = cyc;
    @(negedge clk);
    core_req = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 7'h00;
    #1;
    chk("s3_drain_host_gnt", 64'(host_gnt), 64'd0);
    chk("s3_drain_owner_vld", 64'(owner_vld), 64'd0);
    @(negedge clk);
    host_req = 1'b0;
    wait_owner(1'b1, at);
    chk("s3_switch_cycle", 64'(at), 64'(c_start + int'(RD_LAT) + 1));
    repeat (RD_LAT + 2) @(negedge clk);
    #1;
    chk("s3_core_pulses", 64'(core_pulses - c0), 64'd2);
    chk("s3_host_pulses", 64'(host_pulses - h0), 64'd0);

    // Reset while two host reads are in flight.
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = 7'h06;
    #1;
    chk("s5_rd1_gnt", 64'(host_gnt), 64'd1);
    @(negedge clk);
    host_addr = 7'h07;
    #1;
    chk("s5_rd2_gnt", 64'(host_gnt), 64'd1);
    @(negedge clk);
    host_req = 1'b0; reset = 1'b0;
    h0 = host_pulses; c0 = core_pulses;
    #1;
    chk("s5_rst_cen", 64'(sram_cen), 64'd1);
    chk("s5_rst_owner_vld", 64'(owner_vld), 64'd0);
    chk("s5_rst_rvalid", 64'({host_rvalid, core_rvalid}), 64'd0);
    chk("s5_rst_deny", 64'(deny_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("s5_idle_owner_vld", 64'(owner_vld), 64'd0);
    @(negedge clk); #1;
    chk("s5_own_host", 64'({owner_vld, owner}), 64'b11);
    repeat (RD_LAT + 2) @(negedge clk);
    #1;
    chk("s5_no_rvalid", 64'((host_pulses - h0) + (core_pulses - c0)), 64'd0);

    // Simultaneous requests for 10 cycles with host owning.
    hg = 0; cg = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      host_req = 1'b1; host_we = 1'b1; host_addr = AW'(16 + i); host_wdata = DW'(i);
      core_req = 1'b1; core_we = 1'b1; core_addr = AW'(16 + i); core_wdata = DW'(i);
      #1;
      if (host_gnt) hg++;
      if (core_gnt) cg++;
    end
    @(negedge clk);
    host_req = 1'b0; core_req = 1'b0;
    #1;
    chk("s4_host_gnts", 64'(hg), 64'd10);
    chk("s4_core_gnts", 64'(cg), 64'd0);
    chk("s4_deny_cnt", 64'(deny_cnt), 64'(EXP_DENY));

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
